// File: rtl/leg_servo_phase_driver.sv
// Servo PWM driver for one leg joint: ramps the pulse width between two
// endpoint positions on gait-sequencer strobes and reports settle-complete.
module leg_servo_phase_driver #(
    parameter int unsigned PERIOD        = 1000000,
    parameter int unsigned POS_W         = 20,
    parameter int unsigned POS_A         = 50000,
    parameter int unsigned POS_B         = 100000,
    parameter int unsigned STEP          = 500,
    parameter int unsigned SETTLE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_a,
    input  logic             go_b,
    input  logic             hold,
    output logic             pwm,
    output logic [POS_W-1:0] pos,
    output logic             at_target,
    output logic             done
);

    localparam int unsigned      SET_W    = $clog2(SETTLE_FRAMES + 1);
    localparam logic [POS_W-1:0] CNT_LAST = POS_W'(PERIOD - 1);
    localparam logic [POS_W-1:0] POS_A_W  = POS_W'(POS_A);
    localparam logic [POS_W-1:0] POS_B_W  = POS_W'(POS_B);
    localparam logic [POS_W-1:0] STEP_W   = POS_W'(STEP);
    localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SETTLE_FRAMES);

    logic [POS_W-1:0] cnt;
    logic [POS_W-1:0] target;
    logic [SET_W-1:0] settle;

    logic [POS_W-1:0] cnt_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic [POS_W-1:0] target_nxt;
    logic [SET_W-1:0] settle_nxt;
    logic             pwm_nxt;
    logic             at_target_nxt;
    logic             done_nxt;
    logic             frame_tick_c;
    logic             advance_c;

    assign frame_tick_c = (cnt == CNT_LAST);
    assign advance_c    = frame_tick_c && !hold;

    // Next-state: frame counter, clamped ramp, settle count, target latch
    always_comb begin
        cnt_nxt       = frame_tick_c ? '0 : cnt + POS_W'(1);
        pwm_nxt       = (cnt < pos);
        pos_nxt       = pos;
        target_nxt    = target;
        settle_nxt    = settle;
        at_target_nxt = at_target;
        done_nxt      = 1'b0;

        if (advance_c) begin
            // Differences are taken in the safe direction so the step never wraps
            if (pos < target) begin
                pos_nxt = ((target - pos) <= STEP_W) ? target : pos + STEP_W;
            end else if (pos > target) begin
                pos_nxt = ((pos - target) <= STEP_W) ? target : pos - STEP_W;
            end else if (settle < SET_MAX) begin
                settle_nxt = settle + SET_W'(1);
            end
            at_target_nxt = (settle_nxt == SET_MAX);
        end

        // A load restarts settling; go_a has priority over go_b
        if (go_a || go_b) begin
            target_nxt    = go_a ? POS_A_W : POS_B_W;
            settle_nxt    = '0;
            at_target_nxt = 1'b0;
        end

        done_nxt = at_target_nxt && !at_target;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            pos       <= POS_A_W;
            target    <= POS_A_W;
            settle    <= '0;
            pwm       <= 1'b0;
            at_target <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            pos       <= pos_nxt;
            target    <= target_nxt;
            settle    <= settle_nxt;
            pwm       <= pwm_nxt;
            at_target <= at_target_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_leg_servo_phase_driver.sv
// Frame-level scoreboard bench for leg_servo_phase_driver.
module tb_leg_servo_phase_driver;

    localparam int unsigned PERIOD = 100;
    localparam int unsigned POS_W  = 20;

    typedef struct packed {
        logic [15:0]      width;
        logic [POS_W-1:0] pos;
        logic             at;
        logic [3:0]       dones;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             go_a = 1'b0;
    logic             go_b = 1'b0;
    logic             hold = 1'b0;
    logic             pwm;
    logic [POS_W-1:0] pos;
    logic             at_target;
    logic             done;

    int errors = 0;
    int checks = 0;

    frame_t exp_q[$];
    frame_t obs_q[$];

    int mon_n = 0;
    int mon_width = 0;
    int mon_dones = 0;

    leg_servo_phase_driver #(
        .PERIOD(PERIOD), .POS_W(POS_W), .POS_A(10), .POS_B(40),
        .STEP(10), .SETTLE_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .go_a(go_a), .go_b(go_b), .hold(hold),
        .pwm(pwm), .pos(pos), .at_target(at_target), .done(done)
    );

    always #5 clk = ~clk;

    // Per-frame observation: pwm high count, done pulses, pos/at_target at frame end
    always @(negedge clk) begin
        if (rst) begin
            mon_n = 0;
            mon_width = 0;
            mon_dones = 0;
        end else begin
            mon_n = mon_n + 1;
            mon_width = mon_width + int'(pwm);
            mon_dones = mon_dones + int'(done);
            if (mon_n % PERIOD == 0) begin
                obs_q.push_back({16'(mon_width), pos, at_target, 4'(mon_dones)});
                mon_width = 0;
                mon_dones = 0;
            end
        end
    end

    task automatic push_exp(input int w, input int p, input int a, input int d);
        exp_q.push_back({16'(w), POS_W'(p), 1'(a), 4'(d)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        go_a = 1'b0;
        go_b = 1'b0;
        hold = 1'b0;
        obs_q.delete();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic get_frame(output frame_t f, output bit ok);
        ok = 1'b0;
        f = '0;
        for (int i = 0; i < 2 * PERIOD && !ok; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() > 0) begin
                f = obs_q.pop_front();
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        frame_t exp, got;
        bit ok;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm !== 1'b0 || pos !== POS_W'(10) || at_target !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pwm=%0b pos=%0d at_target=%0b done=%0b, expected 0 10 0 0",
                     pwm, pos, at_target, done);
        end
        do_reset();
        push_exp(10, 10, 0, 0); push_exp(10, 10, 1, 1); push_exp(10, 10, 1, 0);
        for (int r = 1; r <= 3; r++) begin
            get_frame(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL reset_settle frame %0d (ok=%0b): got w=%0d pos=%0d at=%0b done=%0d, expected w=%0d pos=%0d at=%0b done=%0d",
                         r, ok, got.width, got.pos, got.at, got.dones, exp.width, exp.pos, exp.at, exp.dones);
            end
        end
    endtask

    task automatic test_ramp_up();
        frame_t exp, got;
        bit ok;
        do_reset();
        push_exp(10, 10, 0, 0); push_exp(10, 10, 1, 1); push_exp(10, 10, 1, 0);
        push_exp(10, 20, 0, 0); push_exp(20, 30, 0, 0); push_exp(30, 40, 0, 0);
        push_exp(40, 40, 0, 0); push_exp(40, 40, 1, 1);
        for (int r = 1; r <= 8; r++) begin
            get_frame(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL ramp_up frame %0d (ok=%0b): got w=%0d pos=%0d at=%0b done=%0d, expected w=%0d pos=%0d at=%0b done=%0d",
                         r, ok, got.width, got.pos, got.at, got.dones, exp.width, exp.pos, exp.at, exp.dones);
            end
            if (r == 3) begin
                go_b = 1'b1;
                @(negedge clk);
                #1 go_b = 1'b0;
                checks++;
                if (at_target !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp_up_drop: got at_target=%0b, expected 0", at_target);
                end
            end
        end
    endtask

    task automatic test_retarget_down();
        frame_t exp, got;
        bit ok;
        do_reset();
        push_exp(10, 10, 0, 0); push_exp(10, 20, 0, 0); push_exp(20, 30, 0, 0);
        push_exp(30, 20, 0, 0); push_exp(20, 10, 0, 0); push_exp(10, 10, 0, 0);
        push_exp(10, 10, 1, 1); push_exp(10, 10, 1, 0);
        for (int r = 1; r <= 8; r++) begin
            get_frame(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL retarget_down frame %0d (ok=%0b): got w=%0d pos=%0d at=%0b done=%0d, expected w=%0d pos=%0d at=%0b done=%0d",
                         r, ok, got.width, got.pos, got.at, got.dones, exp.width, exp.pos, exp.at, exp.dones);
            end
            if (r == 1 || r == 3) begin
                if (r == 1) go_b = 1'b1;
                else        go_a = 1'b1;
                @(negedge clk);
                #1;
                go_a = 1'b0;
                go_b = 1'b0;
            end
        end
    endtask

    task automatic test_hold();
        frame_t exp, got;
        bit ok;
        do_reset();
        push_exp(10, 10, 0, 0); push_exp(10, 20, 0, 0); push_exp(20, 20, 0, 0);
        push_exp(20, 20, 0, 0); push_exp(20, 20, 0, 0); push_exp(20, 30, 0, 0);
        push_exp(30, 40, 0, 0); push_exp(40, 40, 0, 0); push_exp(40, 40, 1, 1);
        for (int r = 1; r <= 9; r++) begin
            get_frame(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL hold frame %0d (ok=%0b): got w=%0d pos=%0d at=%0b done=%0d, expected w=%0d pos=%0d at=%0b done=%0d",
                         r, ok, got.width, got.pos, got.at, got.dones, exp.width, exp.pos, exp.at, exp.dones);
            end
            if (r == 1) begin
                go_b = 1'b1;
                @(negedge clk);
                #1 go_b = 1'b0;
            end
            if (r == 2) hold = 1'b1;
            if (r == 5) hold = 1'b0;
        end
    endtask

    task automatic test_both_strobes();
        frame_t exp, got;
        bit ok;
        do_reset();
        push_exp(10, 10, 0, 0); push_exp(10, 10, 1, 1); push_exp(10, 10, 0, 0);
        push_exp(10, 10, 1, 1); push_exp(10, 10, 1, 0);
        for (int r = 1; r <= 5; r++) begin
            get_frame(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL both_strobes frame %0d (ok=%0b): got w=%0d pos=%0d at=%0b done=%0d, expected w=%0d pos=%0d at=%0b done=%0d",
                         r, ok, got.width, got.pos, got.at, got.dones, exp.width, exp.pos, exp.at, exp.dones);
            end
            if (r == 2) begin
                go_a = 1'b1;
                go_b = 1'b1;
                @(negedge clk);
                #1;
                go_a = 1'b0;
                go_b = 1'b0;
                checks++;
                if (at_target !== 1'b0) begin
                    errors++;
                    $display("FAIL both_strobes_drop: got at_target=%0b, expected 0", at_target);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        frame_t exp, got;
        bit ok;
        do_reset();
        push_exp(10, 10, 0, 0); push_exp(10, 20, 0, 0); push_exp(20, 30, 0, 0);
        for (int r = 1; r <= 3; r++) begin
            get_frame(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL async_pre frame %0d (ok=%0b): got w=%0d pos=%0d at=%0b done=%0d, expected w=%0d pos=%0d at=%0b done=%0d",
                         r, ok, got.width, got.pos, got.at, got.dones, exp.width, exp.pos, exp.at, exp.dones);
            end
            if (r == 1) begin
                go_b = 1'b1;
                @(negedge clk);
                #1 go_b = 1'b0;
            end
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (pwm !== 1'b1 || pos !== POS_W'(30)) begin
            errors++;
            $display("FAIL async_before: got pwm=%0b pos=%0d, expected 1 30", pwm, pos);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pwm !== 1'b0 || pos !== POS_W'(10) || at_target !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pwm=%0b pos=%0d at_target=%0b done=%0b, expected 0 10 0 0",
                     pwm, pos, at_target, done);
        end
        do_reset();
        push_exp(10, 10, 0, 0); push_exp(10, 10, 1, 1); push_exp(10, 10, 1, 0);
        for (int r = 1; r <= 3; r++) begin
            get_frame(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL async_post frame %0d (ok=%0b): got w=%0d pos=%0d at=%0b done=%0d, expected w=%0d pos=%0d at=%0b done=%0d",
                         r, ok, got.width, got.pos, got.at, got.dones, exp.width, exp.pos, exp.at, exp.dones);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_retarget_down();
        test_hold();
        test_both_strobes();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
